// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: steps from a round key back to the one before it.
// One shared byte-wide S-box substitutes the four SubWord bytes one per cycle.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign y = affine(gf_inv(a));

endmodule

module inv_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         step,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_o,
  output logic         busy,
  output logic         key_valid
);

  typedef enum logic [1:0] {IDLE, XOR, SUB, FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] w1_stg, w2_stg, w3_stg;
  logic [31:0] temp;
  logic [31:0] rot;
  logic [1:0]  cnt;
  logic [7:0]  sbox_in, sbox_out;
  logic        step_ok;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign step_ok = step && key_valid && (round_o != 4'd0);
  assign busy    = (state != IDLE);
  assign rot     = {w3_stg[23:0], w3_stg[31:24]};

  always_comb begin
    sbox_in = rot[31:24];
    case (cnt)
      2'd0: sbox_in = rot[31:24];
      2'd1: sbox_in = rot[23:16];
      2'd2: sbox_in = rot[15:8];
      2'd3: sbox_in = rot[7:0];
      default: sbox_in = rot[31:24];
    endcase
  end

  aes_sbox u_sbox (
    .a (sbox_in),
    .y (sbox_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_ok) state_nxt = XOR;
      XOR:     state_nxt = SUB;
      SUB:     if (cnt == 2'd3) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Staged words and temp stay private until FIN, so the visible key never shows a half-updated schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_key_o <= 128'h0;
      round_o     <= 4'd0;
      key_valid   <= 1'b0;
      cnt         <= 2'd0;
      temp        <= 32'h0;
    end else if (load) begin
      round_key_o <= key_in;
      round_o     <= 4'd10;
      key_valid   <= 1'b1;
      cnt         <= 2'd0;
    end else begin
      case (state)
        IDLE: if (step_ok) key_valid <= 1'b0;
        XOR: begin
          w3_stg <= round_key_o[31:0]  ^ round_key_o[63:32];
          w2_stg <= round_key_o[63:32] ^ round_key_o[95:64];
          w1_stg <= round_key_o[95:64] ^ round_key_o[127:96];
          cnt    <= 2'd0;
        end
        SUB: begin
          case (cnt)
            2'd0: temp[31:24] <= sbox_out;
            2'd1: temp[23:16] <= sbox_out;
            2'd2: temp[15:8]  <= sbox_out;
            2'd3: temp[7:0]   <= sbox_out;
            default: temp[31:24] <= sbox_out;
          endcase
          cnt <= cnt + 2'd1;
        end
        FIN: begin
          round_key_o <= {round_key_o[127:96] ^ temp ^ {rcon(round_o), 24'h0},
                          w1_stg, w2_stg, w3_stg};
          round_o     <= round_o - 4'd1;
          key_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboarded bench for inv_key_expansion against a word-level AES inverse key schedule model.

module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst, load, step;
  logic [127:0] key_in;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         busy, key_valid;

  inv_key_expansion dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .key_in      (key_in),
    .step        (step),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .busy        (busy),
    .key_valid   (key_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] m_key;
  logic [3:0]   m_round;
  logic         m_valid;

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc, x;
    acc = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = (x ^ 32'h11b);
    end
    return acc[7:0];
  endfunction

  // Inverse found by exhaustive search, then the bitwise affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
           ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
    return s;
  endfunction

  function automatic logic [7:0] ref_rcon(input int r);
    int rc;
    rc = 1;
    for (int i = 1; i < r; i++) begin
      rc = rc << 1;
      if (rc > 255) rc = rc ^ 32'h11b;
    end
    return rc[7:0];
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3, rw, t;
    {w0, w1, w2, w3} = k;
    n3 = w3 ^ w2;
    n2 = w2 ^ w1;
    n1 = w1 ^ w0;
    rw = {n3[23:0], n3[31:24]};
    t  = {ref_sbox(rw[31:24]), ref_sbox(rw[23:16]), ref_sbox(rw[15:8]), ref_sbox(rw[7:0])};
    n0 = w0 ^ t ^ {ref_rcon(r), 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic         prev_kv = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_rnd = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (key_valid && (!prev_kv || round_key_o !== prev_key || round_o !== prev_rnd)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got key %h round %0d required no update", round_key_o, round_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_key", round_key_o, e.key);
          check("sb_round", 128'(round_o), 128'(e.rnd));
        end
      end
      prev_kv  = key_valid;
      prev_key = round_key_o;
      prev_rnd = round_o;
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.key = m_key;
    e.rnd = m_round;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; step = 1'b0; key_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_key = '0; m_round = '0; m_valid = 1'b0;
  endtask

  task automatic do_load(input logic [127:0] k);
    load = 1'b1; key_in = k;
    m_key = k; m_round = 4'd10; m_valid = 1'b1;
    push_model();
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic count_busy(output int bc);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
  endtask

  task automatic do_step(output int bc, output bit accepted);
    accepted = m_valid && (m_round != 4'd0);
    if (accepted) begin
      m_key   = inv_step(m_key, int'(m_round));
      m_round = m_round - 4'd1;
      push_model();
    end
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    count_busy(bc);
  endtask

  task automatic busy_window(input int n, output int bc);
    bc = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy) bc++;
    end
  endtask

  initial begin
    int           bc;
    bit           acc;
    logic [127:0] k1, k2, k3, rk;
    rst = 1'b1; load = 1'b0; step = 1'b0; key_in = '0;
    m_key = '0; m_round = '0; m_valid = 1'b0;
    fork
      monitor();
    join_none

    do_reset();
    @(negedge clk);
    check("rst_key", round_key_o, 128'h0);
    check("rst_round", 128'(round_o), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(key_valid), 128'd0);

    do_step(bc, acc);
    check("step_no_load_busy", 128'(bc), 128'd0);
    check("step_no_load_key", round_key_o, 128'h0);
    check("step_no_load_valid", 128'(key_valid), 128'd0);

    do_load(K10);
    @(negedge clk);
    check("load_key", round_key_o, K10);
    check("load_round", 128'(round_o), 128'd10);
    check("load_valid", 128'(key_valid), 128'd1);

    do_step(bc, acc);
    check("step1_busy_len", 128'(bc), 128'd6);
    check("step1_key", round_key_o, K9);
    check("step1_round", 128'(round_o), 128'd9);

    // A second step request raised while busy must be dropped.
    m_key = inv_step(m_key, int'(m_round)); m_round = m_round - 4'd1; push_model();
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (2) @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    count_busy(bc);
    check("step_while_busy_len", 128'(bc), 128'd3);
    busy_window(8, bc);
    check("step_while_busy_ignored", 128'(bc), 128'd0);
    check("step_while_busy_round", 128'(round_o), 128'd8);

    do_load(K10);
    for (int i = 0; i < 10; i++) begin
      m_key = inv_step(m_key, int'(m_round)); m_round = m_round - 4'd1; push_model();
    end
    step = 1'b1;
    busy_window(80, bc);
    step = 1'b0;
    check("held_busy_total", 128'(bc), 128'd60);
    check("held_final_key", round_key_o, K0);
    check("held_final_round", 128'(round_o), 128'd0);
    check("held_final_valid", 128'(key_valid), 128'd1);

    do_step(bc, acc);
    check("round0_step_busy", 128'(bc), 128'd0);
    check("round0_step_key", round_key_o, K0);

    // Load arriving while SUB is on its third byte aborts the step.
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_load(k1);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; key_in = k2;
    m_key = k2; m_round = 4'd10; push_model();
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_key", round_key_o, k2);
    check("abort_round", 128'(round_o), 128'd10);
    busy_window(10, bc);
    check("abort_no_resume", 128'(bc), 128'd0);

    k3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    load = 1'b1; step = 1'b1; key_in = k3;
    m_key = k3; m_round = 4'd10; push_model();
    @(posedge clk);
    #1 load = 1'b0; step = 1'b0;
    busy_window(8, bc);
    check("load_step_busy", 128'(bc), 128'd0);
    check("load_step_key", round_key_o, k3);

    // Reset landing on the FIN edge must leave nothing of the partial update.
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_key = '0; m_round = '0; m_valid = 1'b0;
    @(negedge clk);
    check("fin_rst_key", round_key_o, 128'h0);
    check("fin_rst_round", 128'(round_o), 128'd0);
    check("fin_rst_busy", 128'(busy), 128'd0);
    check("fin_rst_valid", 128'(key_valid), 128'd0);
    do_step(bc, acc);
    check("fin_rst_step_ignored", 128'(bc), 128'd0);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_load(rk);
      for (int s = 0; s < int'($urandom_range(1, 10)); s++) begin
        do_step(bc, acc);
        check("rand_busy_len", 128'(bc), acc ? 128'd6 : 128'd0);
        check("rand_round", 128'(round_o), 128'(m_round));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
